// File: rtl/riscv_alu.sv
// Single-cycle RV32IM integer ALU with a registered result.
// Base ops, M-extension multiply/divide and a B pass-through are all computed combinationally each cycle.
module riscv_alu (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic [4:0]  SELECT,
  output logic [31:0] RESULT
);

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b10000;
  localparam logic [4:0] OP_SLL    = 5'b00001;
  localparam logic [4:0] OP_SLT    = 5'b00010;
  localparam logic [4:0] OP_SLTU   = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_SRA    = 5'b10101;
  localparam logic [4:0] OP_OR     = 5'b00110;
  localparam logic [4:0] OP_AND    = 5'b00111;
  localparam logic [4:0] OP_MUL    = 5'b01000;
  localparam logic [4:0] OP_MULH   = 5'b01001;
  localparam logic [4:0] OP_MULHSU = 5'b01010;
  localparam logic [4:0] OP_MULHU  = 5'b01011;
  localparam logic [4:0] OP_DIV    = 5'b01100;
  localparam logic [4:0] OP_DIVU   = 5'b01101;
  localparam logic [4:0] OP_REM    = 5'b01110;
  localparam logic [4:0] OP_REMU   = 5'b01111;
  localparam logic [4:0] OP_FWD    = 5'b11000;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  function automatic logic [31:0] abs32(input logic signed [31:0] v);
    abs32 = v[31] ? 32'(-v) : 32'(v);
  endfunction

  // Signed divide is done on magnitudes so the zero and overflow corners stay explicit.
  function automatic logic [31:0] div_s(input logic signed [31:0] a, input logic signed [31:0] b);
    logic [31:0] q;
    if (b == 32'sd0)
      div_s = 32'hFFFF_FFFF;
    else if (a == INT_MIN && b == -32'sd1)
      div_s = INT_MIN;
    else begin
      q = abs32(a) / abs32(b);
      div_s = (a[31] ^ b[31]) ? 32'(-q) : q;
    end
  endfunction

  function automatic logic [31:0] rem_s(input logic signed [31:0] a, input logic signed [31:0] b);
    logic [31:0] r;
    if (b == 32'sd0)
      rem_s = a;
    else if (a == INT_MIN && b == -32'sd1)
      rem_s = 32'h0;
    else begin
      r = abs32(a) % abs32(b);
      rem_s = a[31] ? 32'(-r) : r;
    end
  endfunction

  function automatic logic [31:0] div_u(input logic [31:0] a, input logic [31:0] b);
    div_u = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
  endfunction

  function automatic logic [31:0] rem_u(input logic [31:0] a, input logic [31:0] b);
    rem_u = (b == 32'h0) ? a : a % b;
  endfunction

  logic signed [31:0] a_s, b_s;
  logic signed [63:0] a_sx, b_sx;
  logic        [63:0] a_zx, b_zx;
  logic signed [63:0] prod_ss;
  logic        [63:0] prod_su, prod_uu;
  logic signed [31:0] sra_res;
  logic        [4:0]  shamt;
  logic        [31:0] res_p0;

  assign a_s     = DATA1;
  assign b_s     = DATA2;
  assign a_sx    = {{32{DATA1[31]}}, DATA1};
  assign b_sx    = {{32{DATA2[31]}}, DATA2};
  assign a_zx    = {32'h0, DATA1};
  assign b_zx    = {32'h0, DATA2};
  assign prod_ss = a_sx * b_sx;
  assign prod_su = a_sx * b_zx;
  assign prod_uu = a_zx * b_zx;
  assign shamt   = DATA2[4:0];
  assign sra_res = a_s >>> shamt;

  always_comb begin
    res_p0 = 32'h0;
    unique case (SELECT)
      OP_ADD:    res_p0 = DATA1 + DATA2;
      OP_SUB:    res_p0 = DATA1 - DATA2;
      OP_SLL:    res_p0 = DATA1 << shamt;
      OP_SLT:    res_p0 = {31'h0, a_s < b_s};
      OP_SLTU:   res_p0 = {31'h0, DATA1 < DATA2};
      OP_XOR:    res_p0 = DATA1 ^ DATA2;
      OP_SRL:    res_p0 = DATA1 >> shamt;
      OP_SRA:    res_p0 = sra_res;
      OP_OR:     res_p0 = DATA1 | DATA2;
      OP_AND:    res_p0 = DATA1 & DATA2;
      OP_MUL:    res_p0 = prod_uu[31:0];
      OP_MULH:   res_p0 = prod_ss[63:32];
      OP_MULHSU: res_p0 = prod_su[63:32];
      OP_MULHU:  res_p0 = prod_uu[63:32];
      OP_DIV:    res_p0 = div_s(a_s, b_s);
      OP_DIVU:   res_p0 = div_u(DATA1, DATA2);
      OP_REM:    res_p0 = rem_s(a_s, b_s);
      OP_REMU:   res_p0 = rem_u(DATA1, DATA2);
      OP_FWD:    res_p0 = DATA2;
      default:   res_p0 = 32'h0;
    endcase
  end

  // p0 -> p1: result register at the EX/MEM boundary
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)
      RESULT <= 32'h0;
    else
      RESULT <= res_p0;
  end

endmodule

// File: tb/tb_riscv_alu.sv
// Directed bench for riscv_alu: expected results are queued as operations are
// driven and popped against RESULT one cycle later.
module tb_riscv_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data1, data2;
  logic [4:0]  sel;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  riscv_alu dut (
    .CLK    (clk),
    .RESETN (rst_n),
    .DATA1  (data1),
    .DATA2  (data2),
    .SELECT (sel),
    .RESULT (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_now(input string tag, input logic [31:0] exp);
    checks++;
    assert (result === exp) else begin
      errors++;
      $error("FAIL %s: got %08h, required %08h", tag, result, exp);
    end
  endtask

  task automatic step(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    @(negedge clk);
    sel   = op;
    data1 = a;
    data2 = b;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %08h", tag, result);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_now(t, e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 5'b00000;
    data1 = 32'h0000_1234;
    data2 = 32'h0000_0005;
    #3;
    check_now("reset_async_start", 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_held", 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    step(5'b00000, 32'h0000_1234, 32'h0000_0005, 32'h0000_1239, "first_after_reset");

    // Async assert mid-cycle must clear without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_now("reset_async_mid", 32'h0);
    @(posedge clk);
    #1;
    check_now("reset_hold_edge", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step(5'b00000, 32'h8400_0000, 32'h2, 32'h8400_0002, "ADD");
    step(5'b10000, 32'h8400_0000, 32'h2, 32'h83FF_FFFE, "SUB");
    @(negedge clk);
    data1 = 32'hDEAD_BEEF;
    sel   = 5'b00100;
    #1;
    check_now("hold_between_edges", 32'h83FF_FFFE);
    step(5'b00001, 32'h8400_0000, 32'h2, 32'h1000_0000, "SLL");
    step(5'b00100, 32'h8400_0000, 32'h2, 32'h8400_0002, "XOR");
    step(5'b00101, 32'h8400_0000, 32'h2, 32'h2100_0000, "SRL");
    step(5'b10101, 32'h8400_0000, 32'h2, 32'hE100_0000, "SRA");
    step(5'b00110, 32'h8400_0000, 32'h2, 32'h8400_0002, "OR");
    step(5'b00111, 32'h8400_0000, 32'h2, 32'h0000_0000, "AND");
    step(5'b00010, 32'h8400_0000, 32'h2, 32'h0000_0001, "SLT_neg");
    step(5'b00011, 32'h8400_0000, 32'h2, 32'h0000_0000, "SLTU_big");

    step(5'b01000, 32'h8400_0000, 32'h2, 32'h0800_0000, "MUL");
    step(5'b01001, 32'h8400_0000, 32'h2, 32'hFFFF_FFFF, "MULH");
    step(5'b01010, 32'h8400_0000, 32'h2, 32'hFFFF_FFFF, "MULHSU");
    step(5'b01011, 32'h8400_0000, 32'h2, 32'h0000_0001, "MULHU");
    step(5'b01001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "MULH_m1m1");
    step(5'b01010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU_m1max");
    step(5'b01011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU_maxmax");

    step(5'b01100, 32'h8400_0000, 32'h2, 32'hC200_0000, "DIV");
    step(5'b01101, 32'h8400_0000, 32'h2, 32'h4200_0000, "DIVU");
    step(5'b01110, 32'h8400_0000, 32'h2, 32'h0000_0000, "REM");
    step(5'b01111, 32'h8400_0000, 32'h2, 32'h0000_0000, "REMU");

    step(5'b01100, 32'h5, 32'h0, 32'hFFFF_FFFF, "DIV_by0");
    step(5'b01101, 32'h5, 32'h0, 32'hFFFF_FFFF, "DIVU_by0");
    step(5'b01110, 32'h5, 32'h0, 32'h0000_0005, "REM_by0");
    step(5'b01111, 32'h5, 32'h0, 32'h0000_0005, "REMU_by0");
    step(5'b01100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV_ovf");
    step(5'b01110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "REM_ovf");
    step(5'b01100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, "DIV_m7");
    step(5'b01110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, "REM_m7");
    step(5'b01101, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC, "DIVU_m7");
    step(5'b01111, 32'hFFFF_FFF9, 32'h2, 32'h0000_0001, "REMU_m7");

    step(5'b00010, 32'hFFFF_FFFF, 32'h1, 32'h0000_0001, "SLT");
    step(5'b00011, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000, "SLTU");
    step(5'b00010, 32'h1, 32'hFFFF_FFFF, 32'h0000_0000, "SLT_rev");
    step(5'b00011, 32'h1, 32'hFFFF_FFFF, 32'h0000_0001, "SLTU_rev");
    step(5'b00001, 32'h8400_0000, 32'h21, 32'h0800_0000, "SLL_b5ign");
    step(5'b00101, 32'h8400_0000, 32'h21, 32'h4200_0000, "SRL_b5ign");
    step(5'b10101, 32'h8400_0000, 32'h21, 32'hC200_0000, "SRA_b5ign");
    step(5'b10101, 32'h4000_0000, 32'h1F, 32'h0000_0000, "SRA_pos31");
    step(5'b11000, 32'hAAAA_5555, 32'h1234_5000, 32'h1234_5000, "FWD");
    step(5'b11111, 32'h8400_0000, 32'h2, 32'h0000_0000, "UNDEF_11111");
    step(5'b10001, 32'h8400_0000, 32'h2, 32'h0000_0000, "UNDEF_10001");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
